cpu_memory: RTL and testbench

CPU_MEMORY -- requirements
Module: cpu_memory

---
 rtl/cpu_memory_pkg.sv | 12 +
 rtl/cpu_memory_lane.sv | 23 ++
 rtl/cpu_memory.sv | 116 +++++++++++
 tb/tb_cpu_memory.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cpu_memory_pkg.sv
// cpu_memory_pkg: shared control-bit indices, size codes and state encoding for the memory stage.
package cpu_memory_pkg;
    localparam int PCB_WIDTH = 4;
    localparam int PCB_WA = 0;
    localparam int PCB_WB = 1;
    localparam int PCB_RM = 2;
    localparam int PCB_WM = 3;
    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_SHORT = 2'b01;
    localparam logic [1:0] SIZE_LONG  = 2'b10;
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT_HI = 2'd1, BEAT_LO = 2'd2} state_e;
endpackage

// File: rtl/cpu_memory_lane.sv
// cpu_memory_lane: big-endian byte-lane steering for the 16-bit data bus.
module cpu_memory_lane
    import cpu_memory_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        addr0_i,
    input  logic        beat_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [15:0] rdata_i,
    output logic [1:0]  sel_o,
    output logic [15:0] wdata_o,
    output logic [15:0] rdata_o
);
    logic is_byte;
    assign is_byte = size_i == SIZE_BYTE;
    always_comb begin
        sel_o   = !is_byte ? 2'b11 : addr0_i ? 2'b01 : 2'b10;
        wdata_o = size_i == SIZE_LONG ? (beat_lo_i ? wdata_i[15:0] : wdata_i[31:16])
                : !is_byte ? wdata_i[15:0]
                : addr0_i ? {8'h00, wdata_i[7:0]} : {wdata_i[7:0], 8'h00};
        rdata_o = !is_byte ? rdata_i : addr0_i ? {8'h00, rdata_i[7:0]} : {8'h00, rdata_i[15:8]};
    end
endmodule

// File: rtl/cpu_memory.sv
// cpu_memory: memory pipeline stage; drives a 16-bit Wishbone data port and registers writeback.
module cpu_memory #(
    parameter int PCB_WIDTH = cpu_memory_pkg::PCB_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic [PCB_WIDTH-1:0] pipeline_control_bits_i,
    input  logic [1:0]           size_i,
    input  logic [31:0]          memory_address_i,
    input  logic [31:0]          mem_result_i,
    input  logic [31:0]          reg0_result_i,
    input  logic [31:0]          reg1_result_i,
    input  logic [3:0]           register0_write_index_i,
    input  logic [3:0]           register1_write_index_i,
    output logic [31:0]          dmem_address_o,
    output logic [15:0]          dmem_data_o,
    input  logic [15:0]          dmem_data_i,
    output logic [1:0]           dmem_sel_o,
    output logic                 dmem_we_o,
    output logic                 dmem_stb_o,
    output logic                 dmem_cyc_o,
    input  logic                 dmem_ack_i,
    output logic                 stall_o,
    output logic                 register_wea_o,
    output logic                 register_web_o,
    output logic [3:0]           register0_write_index_o,
    output logic [3:0]           register1_write_index_o,
    output logic [31:0]          reg0_result_o,
    output logic [31:0]          reg1_result_o
);
    import cpu_memory_pkg::*;
    state_e state_q, state_d;
    logic [PCB_WIDTH-1:0] pcb_q, pcb_d, pcb_in;
    logic [1:0] size_q, size_d, sel_q, sel_d, lane_size, lane_sel;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, reg0_q, reg0_d, reg1_q, reg1_d, load_val, lane_win;
    logic [15:0] dout_q, dout_d, hi_q, hi_d, lane_wdata, lane_rdata;
    logic [3:0] idx0_q, idx0_d, idx1_q, idx1_d;
    logic we_q, we_d, cyc_q, cyc_d, wea_q, wea_d, web_q, web_d, flushed_q, flushed_d;
    logic idle, mem_in, kill, last;
    assign idle      = state_q == IDLE;
    assign lane_size = idle ? size_i : size_q;
    assign lane_win  = idle ? mem_result_i : wdata_q;
    cpu_memory_lane u_lane (
        .size_i    (lane_size),
        .addr0_i   (idle ? memory_address_i[0] : addr_q[0]),
        .beat_lo_i (state_q == BEAT_HI),
        .wdata_i   (lane_win),
        .rdata_i   (dmem_data_i),
        .sel_o     (lane_sel),
        .wdata_o   (lane_wdata),
        .rdata_o   (lane_rdata)
    );
    always_comb begin
        pcb_in   = flush_i ? '0 : pipeline_control_bits_i;
        mem_in   = pcb_in[PCB_RM] | pcb_in[PCB_WM];
        kill     = flushed_q | flush_i;
        last     = dmem_ack_i & ((state_q == BEAT_LO) | (state_q == BEAT_HI && size_q != SIZE_LONG));
        load_val = size_q == SIZE_LONG ? {hi_q, dmem_data_i} : {16'h0000, lane_rdata};
        state_d = state_q; pcb_d = pcb_q; size_d = size_q; sel_d = sel_q; addr_d = addr_q;
        wdata_d = wdata_q; reg0_d = reg0_q; reg1_d = reg1_q; dout_d = dout_q; hi_d = hi_q;
        idx0_d = idx0_q; idx1_d = idx1_q; we_d = we_q; cyc_d = cyc_q; flushed_d = flushed_q;
        wea_d = 1'b0;
        web_d = 1'b0;
        if (idle) begin
            pcb_d = pcb_in; size_d = size_i; wdata_d = mem_result_i; flushed_d = 1'b0;
            idx0_d = register0_write_index_i; idx1_d = register1_write_index_i;
            reg0_d = reg0_result_i; reg1_d = reg1_result_i;
            wea_d = ~mem_in & pcb_in[PCB_WA];
            web_d = ~mem_in & pcb_in[PCB_WB];
            if (mem_in) begin
                state_d = BEAT_HI; cyc_d = 1'b1; we_d = pcb_in[PCB_WM];
                sel_d = lane_sel; dout_d = lane_wdata;
                addr_d = size_i == SIZE_SHORT ? {memory_address_i[31:1], 1'b0} : memory_address_i;
            end
        end else begin
            flushed_d = kill;
            if (dmem_ack_i && state_q == BEAT_HI && size_q == SIZE_LONG) begin
                state_d = BEAT_LO; hi_d = dmem_data_i; addr_d = addr_q + 32'd2; dout_d = lane_wdata;
            end
            // Final beat: release the bus and present writeback for one cycle unless squashed.
            if (last) begin
                state_d = IDLE; cyc_d = 1'b0; we_d = 1'b0; sel_d = 2'b00;
                wea_d = ~kill & pcb_q[PCB_WA];
                web_d = ~kill & pcb_q[PCB_WB];
                if (pcb_q[PCB_RM]) reg0_d = load_val;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE; pcb_q <= '0; size_q <= '0; sel_q <= '0; addr_q <= '0;
            wdata_q <= '0; reg0_q <= '0; reg1_q <= '0; dout_q <= '0; hi_q <= '0;
            idx0_q <= '0; idx1_q <= '0; we_q <= 1'b0; cyc_q <= 1'b0; flushed_q <= 1'b0;
            wea_q <= 1'b0; web_q <= 1'b0;
        end else begin
            state_q <= state_d; pcb_q <= pcb_d; size_q <= size_d; sel_q <= sel_d; addr_q <= addr_d;
            wdata_q <= wdata_d; reg0_q <= reg0_d; reg1_q <= reg1_d; dout_q <= dout_d; hi_q <= hi_d;
            idx0_q <= idx0_d; idx1_q <= idx1_d; we_q <= we_d; cyc_q <= cyc_d; flushed_q <= flushed_d;
            wea_q <= wea_d; web_q <= web_d;
        end
    end
    assign stall_o                 = state_q != IDLE;
    assign dmem_address_o          = addr_q;
    assign dmem_data_o             = dout_q;
    assign dmem_sel_o              = sel_q;
    assign dmem_we_o               = we_q;
    assign dmem_stb_o              = cyc_q;
    assign dmem_cyc_o              = cyc_q;
    assign register_wea_o          = wea_q;
    assign register_web_o          = web_q;
    assign register0_write_index_o = idx0_q;
    assign register1_write_index_o = idx1_q;
    assign reg0_result_o           = reg0_q;
    assign reg1_result_o           = reg1_q;
endmodule

// File: tb/tb_cpu_memory.sv
// tb_cpu_memory: directed vectors with hand-computed expectations for the memory stage.
module tb_cpu_memory;
    logic clk_i = 1'b0, rst_i, flush_i, dmem_ack_i;
    logic [3:0] pcb_i, idx0_i, idx1_i, idx0_o, idx1_o;
    logic [1:0] size_i, sel_o;
    logic [31:0] addr_i, mres_i, r0_i, r1_i, addr_o, r0_o, r1_o;
    logic [15:0] ddat_o, ddat_i;
    logic we_o, stb_o, cyc_o, stall_o, wea_o, web_o;
    int n_cmp = 0, n_bad = 0;
    always #5 clk_i = ~clk_i;
    cpu_memory dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .pipeline_control_bits_i(pcb_i),
        .size_i(size_i), .memory_address_i(addr_i), .mem_result_i(mres_i),
        .reg0_result_i(r0_i), .reg1_result_i(r1_i),
        .register0_write_index_i(idx0_i), .register1_write_index_i(idx1_i),
        .dmem_address_o(addr_o), .dmem_data_o(ddat_o), .dmem_data_i(ddat_i), .dmem_sel_o(sel_o),
        .dmem_we_o(we_o), .dmem_stb_o(stb_o), .dmem_cyc_o(cyc_o), .dmem_ack_i(dmem_ack_i),
        .stall_o(stall_o), .register_wea_o(wea_o), .register_web_o(web_o),
        .register0_write_index_o(idx0_o), .register1_write_index_o(idx1_o),
        .reg0_result_o(r0_o), .reg1_result_o(r1_o)
    );
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask
    task automatic idle_in();
        pcb_i = 4'b0000; flush_i = 1'b0; dmem_ack_i = 1'b0; ddat_i = 16'h0000;
    endtask
    task automatic issue(input logic [3:0] pcb, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] i0);
        pcb_i = pcb; size_i = sz; addr_i = a; mres_i = d; idx0_i = i0;
    endtask
    initial begin
        rst_i = 1'b1; idle_in(); size_i = 2'b00; addr_i = '0; mres_i = '0;
        r0_i = '0; r1_i = '0; idx0_i = '0; idx1_i = '0;
        step(); step();
        check("rst_stall", {31'b0, stall_o}, 0);
        check("rst_cyc", {31'b0, cyc_o}, 0);
        check("rst_wea", {30'b0, wea_o, web_o}, 0);
        check("rst_data", r0_o | r1_o | {24'b0, idx0_o, idx1_o}, 0);
        rst_i = 1'b0;
        // ADD: write port 0 only, one cycle later
        issue(4'b0001, 2'b00, 32'h0, 32'h0, 4'd3); r0_i = 32'h12345678; r1_i = 32'h0000_0055;
        step();
        check("add_wea", {31'b0, wea_o}, 1);
        check("add_web", {31'b0, web_o}, 0);
        check("add_idx", {28'b0, idx0_o}, 3);
        check("add_r0", r0_o, 32'h12345678);
        check("add_r1", r1_o, 32'h55);
        check("add_cyc", {31'b0, cyc_o}, 0);
        idle_in();
        step();
        check("add_wea_pulse", {31'b0, wea_o}, 0);
        // store long 0xDEADBEEF to 0x100, ack every cycle
        issue(4'b1000, 2'b10, 32'h100, 32'hDEADBEEF, 4'd0); dmem_ack_i = 1'b1;
        step();
        pcb_i = 4'b0000;
        check("stl_b1", {addr_o[15:0], ddat_o}, 32'h0100_DEAD);
        check("stl_b1_ctl", {26'b0, sel_o, we_o, stb_o, cyc_o, stall_o}, 32'h3F);
        step();
        check("stl_b2", {addr_o[15:0], ddat_o}, 32'h0102_BEEF);
        check("stl_b2_stall", {31'b0, stall_o}, 1);
        step();
        check("stl_end", {28'b0, cyc_o, stb_o, stall_o, wea_o}, 0);
        idle_in();
        // load byte from odd address 0x101
        issue(4'b0101, 2'b00, 32'h101, 32'h0, 4'd5); r0_i = 32'hFFFF_FFFF;
        step();
        pcb_i = 4'b0000;
        check("ldb_bus", {addr_o[15:0], 11'b0, sel_o, we_o, cyc_o, stall_o}, 32'h0101_000B);
        dmem_ack_i = 1'b1; ddat_i = 16'h00AB;
        step();
        check("ldb_r0", r0_o, 32'h000000AB);
        check("ldb_wb", {27'b0, wea_o, idx0_o}, 32'h15);
        check("ldb_cyc", {30'b0, cyc_o, stall_o}, 0);
        idle_in();
        step();
        check("ldb_wea_pulse", {31'b0, wea_o}, 0);
        // store byte to even address: high lane
        issue(4'b1000, 2'b00, 32'h10, 32'h0000_005A, 4'd0);
        step();
        pcb_i = 4'b0000;
        check("stb_even", {ddat_o, 14'b0, sel_o}, 32'h5A00_0002);
        dmem_ack_i = 1'b1;
        step();
        check("stb_end", {31'b0, cyc_o}, 0);
        idle_in();
        // load long 0x200 with three wait-states on the first beat
        issue(4'b0101, 2'b10, 32'h200, 32'h0, 4'd7);
        step();
        pcb_i = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            check("ldl_wait", {addr_o[15:0], 12'b0, sel_o, cyc_o, stall_o}, 32'h0200_000F);
            step();
        end
        check("ldl_wait_end", {addr_o[15:0], 12'b0, sel_o, cyc_o, stall_o}, 32'h0200_000F);
        dmem_ack_i = 1'b1; ddat_i = 16'hCAFE;
        step();
        check("ldl_b2", {addr_o[15:0], 14'b0, stall_o, wea_o}, 32'h0202_0002);
        ddat_i = 16'hF00D;
        step();
        check("ldl_r0", r0_o, 32'hCAFEF00D);
        check("ldl_wb", {26'b0, stall_o, wea_o, idx0_o}, 32'h17);
        idle_in();
        // load long with flush during BEAT_LO (on a wait-state)
        issue(4'b0101, 2'b10, 32'h300, 32'h0, 4'd2); dmem_ack_i = 1'b1; ddat_i = 16'h1111;
        step();
        pcb_i = 4'b0000;
        step();
        flush_i = 1'b1; dmem_ack_i = 1'b0;
        step();
        check("ldf_held", {addr_o[15:0], 14'b0, cyc_o, stall_o}, 32'h0302_0003);
        flush_i = 1'b0; dmem_ack_i = 1'b1; ddat_i = 16'h2222;
        step();
        check("ldf_done", {29'b0, cyc_o, stall_o, wea_o}, 0);
        idle_in();
        // flush coinciding with the final ack of a short load
        issue(4'b0101, 2'b01, 32'h41, 32'h0, 4'd9);
        step();
        pcb_i = 4'b0000;
        check("lds_addr", addr_o, 32'h40);
        flush_i = 1'b1; dmem_ack_i = 1'b1; ddat_i = 16'h7777;
        step();
        check("lds_flush_ack", {30'b0, cyc_o, wea_o}, 0);
        idle_in();
        // flush in IDLE squashes a load entirely
        issue(4'b0111, 2'b00, 32'h50, 32'h0, 4'd1); flush_i = 1'b1;
        step();
        check("idle_flush", {28'b0, cyc_o, stall_o, wea_o, web_o}, 0);
        idle_in();
        // reset during BEAT_HI of a short store
        issue(4'b1011, 2'b01, 32'h401, 32'h0000BEEF, 4'd4);
        step();
        pcb_i = 4'b0000;
        check("rst_mid_bus", {addr_o[15:0], ddat_o}, 32'h0400_BEEF);
        check("rst_mid_cyc", {31'b0, cyc_o}, 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rst_mid_drop", {28'b0, cyc_o, stall_o, wea_o, web_o}, 0);
        dmem_ack_i = 1'b1;
        step();
        check("rst_mid_nowb", {28'b0, cyc_o, stall_o, wea_o, web_o}, 0);
        idle_in();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
